// File: rtl/lab_pkg.sv
// Shared screen geometry, buffer depth and pixel record for the circle-drawer lab.
package lab_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int PLOT_DEPTH = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } plot_state_e;

  // True when the pixel lands outside the visible raster.
  function automatic logic off_screen(input logic [7:0] x, input logic [6:0] y);
    return (x >= 8'(SCREEN_W)) || (y >= 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/plot_buffer_if.sv
// Pixel stream bundle: drawer-side push port and adapter-side FWFT head port.
interface plot_buffer_if;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic       out_ready;

  // The buffer consumes pixels and produces the head entry.
  modport slave (
    input  in_x, in_y, in_colour, in_plot, out_ready,
    output out_x, out_y, out_colour, out_plot
  );

  // The environment (drawer + adapter) drives the opposite directions.
  modport master (
    output in_x, in_y, in_colour, in_plot, out_ready,
    input  out_x, out_y, out_colour, out_plot
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through storage; caller guarantees push only when
// not full or popping, and pop only when not empty.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH for free.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // When full, a same-edge push lands on the slot being popped; the head was
  // already consumed combinationally, so the overwrite is safe.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/plot_buffer.sv
// Pixel FIFO between circle drawer and VGA adapter, with sticky overflow and
// optional off-screen clipping (enable with `define PLOT_CLIP_EN).
module plot_buffer
  import lab_pkg::*;
#(
  parameter int DEPTH = PLOT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  plot_buffer_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            clip_count,
  output logic                   idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  plot_state_e   state_q, state_d;
  pixel_t        in_px, head_px;
  logic          clipped, cand, push, pop, drop, have_head;
  logic          overflow_q, overflow_d;
  logic [15:0]   clip_q, clip_d;
  logic [CW-1:0] fifo_count;

`ifdef PLOT_CLIP_EN
  assign clipped = off_screen(bus.in_x, bus.in_y);
`else
  assign clipped = 1'b0;
`endif

  assign in_px     = '{x: bus.in_x, y: bus.in_y, colour: bus.in_colour};
  assign have_head = (state_q != ST_EMPTY);
  assign cand      = bus.in_plot && !clipped && !flush;
  assign pop       = have_head && bus.out_ready && !flush;
  assign push      = cand && ((state_q != ST_FULL) || pop);
  assign drop      = cand && (state_q == ST_FULL) && !pop;

  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_px),
    .rdata (head_px),
    .count (fifo_count)
  );

  // Occupancy class tracks the FIFO count; edges only at the 0/1 and
  // DEPTH-1/DEPTH boundaries where push and pop are unbalanced.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:  if (push) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (push && !pop && fifo_count == CW'(DEPTH - 1))
            state_d = ST_FULL;
          else if (pop && !push && fifo_count == CW'(1))
            state_d = ST_EMPTY;
        end
        ST_FULL:   if (pop && !push) state_d = ST_ACTIVE;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    clip_d     = clip_q;
    if (bus.in_plot && clipped && clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      overflow_q <= 1'b0;
      clip_q     <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      clip_q     <= clip_d;
    end
  end

  assign bus.out_plot   = have_head;
  assign bus.out_x      = have_head ? head_px.x      : '0;
  assign bus.out_y      = have_head ? head_px.y      : '0;
  assign bus.out_colour = have_head ? head_px.colour : '0;

  assign count      = fifo_count;
  assign overflow   = overflow_q;
  assign clip_count = clip_q;
  assign idle       = !have_head && !bus.in_plot;

endmodule

// File: tb/tb_plot_buffer.sv
// Self-checking bench for plot_buffer: queue scoreboard plus table and corner sequences.
module tb_plot_buffer;
  import lab_pkg::*;

  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [CW-1:0] count;
  logic          overflow, idle;
  logic [15:0]   clip_count;

  plot_buffer_if bus();

  plot_buffer #(.DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .count      (count),
    .overflow   (overflow),
    .clip_count (clip_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  pixel_t      q[$];
  logic        m_ovf;
  logic [15:0] m_clip;

  typedef struct {
    logic          pl;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    c;
    logic          rd;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_clipped(input logic [7:0] x, input logic [6:0] y);
`ifdef PLOT_CLIP_EN
    return (x >= 8'd160) || (y >= 7'd120);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive, compare pre-edge outputs against the model, advance model.
  task automatic cycle(input logic r, input logic fl, input logic pl,
                       input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input logic rd);
    logic pop, acc, clp;
    pixel_t exp_head;
    rst = r; flush = fl;
    bus.in_plot = pl; bus.in_x = x; bus.in_y = y; bus.in_colour = c;
    bus.out_ready = rd;
    @(negedge clk);
    exp_head = (q.size() != 0) ? q[0] : '0;
    chk("count", 32'(count), 32'(q.size()));
    chk("out_plot", 32'(bus.out_plot), 32'(q.size() != 0));
    chk("head", {14'd0, bus.out_x, bus.out_y, bus.out_colour}, {14'd0, exp_head});
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("clip_count", 32'(clip_count), 32'(m_clip));
    chk("idle", 32'(idle), 32'(q.size() == 0 && !pl));
    clp = m_clipped(x, y);
    pop = (q.size() != 0) && rd && !fl;
    acc = pl && !clp && !fl && (q.size() < D || pop);
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_clip = '0;
    end else begin
      if (pl && clp && m_clip != 16'hFFFF) m_clip++;
      if (fl) q.delete();
      else begin
        if (pl && !clp && q.size() == D && !pop) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{x: x, y: y, colour: c});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input logic rd);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, rd);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 8'd10, 7'd20, 3'd3, 1'b0, 5'd1};
    tbl[1] = '{1'b1, 8'd11, 7'd21, 3'd4, 1'b0, 5'd2};
    tbl[2] = '{1'b1, 8'd12, 7'd22, 3'd5, 1'b0, 5'd3};
    tbl[3] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 5'd2};
    tbl[4] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 5'd1};
    tbl[5] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 5'd0};
    tbl[6] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 5'd0};
    tbl[7] = '{1'b1, 8'd1,  7'd2,  3'd3, 1'b1, 5'd1};
    tbl[8] = '{1'b1, 8'd4,  7'd5,  3'd6, 1'b1, 5'd1};
    tbl[9] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 5'd0};

    rst = 1'b1; flush = 1'b0;
    bus.in_plot = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_colour = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ovf = 1'b0; m_clip = '0; q.delete();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_plot", 32'(bus.out_plot), 32'd0);
    chk("rst_head", {14'd0, bus.out_x, bus.out_y, bus.out_colour}, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);

    // Ordering, empty pop, push-on-empty and push+pop at count==1.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, tbl[i].pl, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].rd);
      chk("tbl_count", 32'(count), 32'(tbl[i].exp_cnt));
    end

    // Overflow: 17 pushes into a stalled buffer.
    for (int i = 0; i < 17; i++)
      cycle(1'b0, 1'b0, 1'b1, 8'(i + 32), 7'(i + 40), 3'(i), 1'b0);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (16) idle_cyc(1'b1);
    chk("ovf_drained", 32'(count), 32'd0);

    // Flush with a same-cycle push; overflow must survive.
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 1'b0, 1'b1, 8'(i + 70), 7'(i), 3'(i), 1'b0);
    chk("pre_flush", 32'(count), 32'd7);
    cycle(1'b0, 1'b1, 1'b1, 8'd50, 7'd50, 3'd1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_plot", 32'(bus.out_plot), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd1);

    // Mid-stream reset with count==5 and live traffic.
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b0, 1'b1, 8'(i + 5), 7'(i + 6), 3'(i), 1'b0);
    chk("pre_rst", 32'(count), 32'd5);
    cycle(1'b1, 1'b0, 1'b1, 8'd9, 7'd9, 3'd2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 8'd9, 7'd9, 3'd2, 1'b1);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_plot", 32'(bus.out_plot), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_clip", 32'(clip_count), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b0, 1'b1, 8'(i + 100), 7'(i + 10), 3'(i + 1), 1'b0);
    chk("full_count", 32'(count), 32'd16);
    cycle(1'b0, 1'b0, 1'b1, 8'd99, 7'd99, 3'd6, 1'b1);
    chk("fpp_count", 32'(count), 32'd16);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    repeat (15) idle_cyc(1'b1);
    chk("fpp_last", {14'd0, bus.out_x, bus.out_y, bus.out_colour},
        {14'd0, 8'd99, 7'd99, 3'd6});
    idle_cyc(1'b1);
    chk("fpp_drained", 32'(count), 32'd0);

    // Clipping boundaries.
    cycle(1'b0, 1'b0, 1'b1, 8'd159, 7'd119, 3'd7, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'd160, 7'd0,   3'd1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'd0,   7'd120, 3'd2, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'd255, 7'd127, 3'd3, 1'b0);
`ifdef PLOT_CLIP_EN
    chk("clip_count_n", 32'(count), 32'd1);
    chk("clip_cnt", 32'(clip_count), 32'd3);
`else
    chk("clip_count_n", 32'(count), 32'd4);
    chk("clip_cnt", 32'(clip_count), 32'd0);
`endif
    repeat (4) idle_cyc(1'b1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++)
      cycle(1'b0, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0),
            8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
    repeat (17) idle_cyc(1'b1);
    chk("final_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
